// File: rtl/shuffle_pipe_n_if.sv
// Handshake and data bundle for shuffle_pipe_n: upstream beat channel plus downstream
// shuffled-beat channel with polynomial beat counter.
interface shuffle_pipe_n_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned W     = 256,
    parameter int unsigned BEATS = 32
);
    localparam int unsigned CW = ($clog2(BEATS) > 0) ? $clog2(BEATS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_cros;
    logic [1:0]           in_mode;
    logic [LANES*W-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_data;
    logic                 out_last;
    logic [CW-1:0]        beat_cnt;

    // master drives beats in and consumes shuffled beats; slave is the shuffle block
    modport master (
        output in_valid, in_cros, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, beat_cnt
    );

    modport slave (
        input  in_valid, in_cros, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, beat_cnt
    );
endinterface

// File: rtl/shuffle_pipe_n.sv
// Elastic two-stage lane shuffle: stage 1 optional half-swap, stage 2 per-beat
// pass / NTT perfect-shuffle / INTT de-interleave, with per-polynomial beat counting.
module shuffle_pipe_n #(
    parameter int unsigned LANES = 8,
    parameter int unsigned W     = 256,
    parameter int unsigned BEATS = 32
) (
    input logic             clk,
    input logic             rst,
    shuffle_pipe_n_if.slave bus
);
    localparam int unsigned H  = LANES / 2;
    localparam int unsigned DW = LANES * W;
    localparam int unsigned CW = ($clog2(BEATS) > 0) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        ModePass = 2'b00,
        ModeNtt  = 2'b01,
        ModeIntt = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    logic          s1_v_q, s1_v_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    mode_e         s1_mode_q, s1_mode_d;
    logic          s2_v_q, s2_v_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          s1_load, s2_load, in_fire, out_fire;
    logic [DW-1:0] cross_data, perm_data;

    assign s2_load  = !s2_v_q || bus.out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_fire  = bus.in_valid && s1_load;
    assign out_fire = s2_v_q && bus.out_ready;

    always_comb begin
        cross_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_cros) cross_data[i*W +: W] = bus.in_data[(i ^ H)*W +: W];
            else             cross_data[i*W +: W] = bus.in_data[i*W +: W];
        end
    end

    always_comb begin
        perm_data = s1_data_q;
        case (s1_mode_q)
            ModeNtt: begin
                for (int i = 0; i < H; i++) begin
                    perm_data[(2*i)*W +: W]   = s1_data_q[i*W +: W];
                    perm_data[(2*i+1)*W +: W] = s1_data_q[(i+H)*W +: W];
                end
            end
            ModeIntt: begin
                for (int i = 0; i < H; i++) begin
                    perm_data[i*W +: W]     = s1_data_q[(2*i)*W +: W];
                    perm_data[(i+H)*W +: W] = s1_data_q[(2*i+1)*W +: W];
                end
            end
            default: perm_data = s1_data_q;
        endcase
    end

    // Empty stages carry zero data so out_data is clean whenever out_valid is low.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_mode_d = s1_mode_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        cnt_d     = cnt_q;
        if (s1_load) begin
            s1_v_d    = in_fire;
            s1_data_d = in_fire ? cross_data : '0;
            s1_mode_d = in_fire ? mode_e'(bus.in_mode) : ModePass;
        end
        if (s2_load) begin
            s2_v_d    = s1_v_q;
            s2_data_d = s1_v_q ? perm_data : '0;
        end
        if (out_fire) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= ModePass;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_mode_q <= s1_mode_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_v_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_last  = s2_v_q && (cnt_q == LastCnt);
    assign bus.beat_cnt  = cnt_q;
endmodule

// File: tb/tb_shuffle_pipe_n.sv
// Scoreboard bench for shuffle_pipe_n: expected beats queued at input acceptance,
// compared against the output head every cycle it is valid.
module tb_shuffle_pipe_n;
    localparam int unsigned LANES = 8;
    localparam int unsigned W     = 16;
    localparam int unsigned BEATS = 4;
    localparam int unsigned H     = LANES / 2;
    localparam int unsigned DW    = LANES * W;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mcnt = 0;
    int   bp_mode = 0;
    int   bp_base = 0;
    logic          dir_use = 1'b0;
    logic [DW-1:0] dir_exp = '0;
    exp_t q[$];

    shuffle_pipe_n_if #(.LANES(LANES), .W(W), .BEATS(BEATS)) b ();

    shuffle_pipe_n #(.LANES(LANES), .W(W), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic c,
                                            input logic [1:0] m);
        logic [DW-1:0] x, o;
        int src;
        for (int j = 0; j < LANES; j++)
            x[j*W +: W] = c ? d[((j + H) % LANES)*W +: W] : d[j*W +: W];
        for (int j = 0; j < LANES; j++) begin
            src = j;
            if (m == 2'b01)      src = (j % 2 == 0) ? j / 2 : j / 2 + H;
            else if (m == 2'b10) src = (j < H) ? 2 * j : 2 * (j - H) + 1;
            o[j*W +: W] = x[src*W +: W];
        end
        return o;
    endfunction

    function automatic logic [DW-1:0] seq(input logic [31:0] idx);
        logic [DW-1:0] o;
        for (int j = 0; j < LANES; j++) o[j*W +: W] = W'(idx[4*j +: 4]);
        return o;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] o;
        for (int j = 0; j < LANES; j++) o[j*W +: W] = W'($urandom);
        return o;
    endfunction

    // Monitor: check outputs against the queue head, then apply this edge's transfers.
    always @(negedge clk) begin
        logic exp_v;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            exp_v = (q.size() > 0) && (cyc - q[0].t >= 2);
            check_eq("out_valid", DW'(b.out_valid), DW'(exp_v));
            check_eq("in_ready", DW'(b.in_ready), DW'((q.size() < 2) || b.out_ready));
            if (exp_v) begin
                check_eq("out_data", b.out_data, q[0].d);
                check_eq("beat_cnt", DW'(b.beat_cnt), DW'(mcnt));
                check_eq("out_last", DW'(b.out_last), DW'(mcnt == BEATS - 1));
            end else begin
                check_eq("idle_data", b.out_data, '0);
                check_eq("idle_last", DW'(b.out_last), '0);
            end
            if (b.in_valid && b.in_ready)
                q.push_back('{d: dir_use ? dir_exp : model(b.in_data, b.in_cros, b.in_mode),
                              t: cyc});
            if (b.out_valid && b.out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                mcnt = (mcnt + 1) % BEATS;
            end
        end
    end

    initial begin
        b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       b.out_ready = !((cyc - bp_base >= 3) && (cyc - bp_base <= 8));
                2:       b.out_ready = ($urandom_range(0, 3) != 0);
                default: b.out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic c, input logic [1:0] m,
                        input logic use_dir, input logic [DW-1:0] e);
        logic acc;
        acc = 1'b0;
        b.in_valid = 1'b1;
        b.in_data  = d;
        b.in_cros  = c;
        b.in_mode  = m;
        dir_use    = use_dir;
        dir_exp    = e;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = b.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        b.in_valid = 1'b0;
        dir_use    = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] x;
        // A beat offered during reset must be dropped.
        b.in_valid = 1'b1;
        b.in_data  = seq(32'h76543210);
        b.in_cros  = 1'b0;
        b.in_mode  = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        b.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(seq(32'h76543210), 1'b0, 2'b01, 1'b1, seq(32'h73625140));
        send(seq(32'h76543210), 1'b1, 2'b01, 1'b1, seq(32'h37261504));
        send(seq(32'h76543210), 1'b0, 2'b10, 1'b1, seq(32'h75316420));
        drain();

        for (int i = 0; i < 300; i++) begin
            if (i == 150) bp_mode = 2;
            x = rand_beat();
            send(x, 1'b0, 2'b01, 1'b0, '0);
            send(model(x, 1'b0, 2'b01), 1'b0, 2'b10, 1'b1, x);
        end
        bp_mode = 0;
        drain();

        bp_base = cyc;
        bp_mode = 1;
        for (int i = 0; i < 10; i++) send(rand_beat(), i[0], 2'(i % 3), 1'b0, '0);
        drain();
        bp_mode = 0;

        for (int i = 0; i < 3; i++) send(rand_beat(), 1'b0, 2'b01, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) send(seq(32'h76543210 + i), 1'b0, 2'b00, 1'b0, '0);
        drain();

        for (int i = 0; i < 40; i++)
            send(rand_beat(), 1'($urandom_range(0, 1)), 2'(i % 4), 1'b0, '0);
        drain();

        bp_mode = 2;
        for (int i = 0; i < 200; i++)
            send(rand_beat(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, '0);
        bp_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
